// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO and compile-time frame format.
// Frames are start, DATA_BITS data bits LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_cfg #(
    parameter int CLK_DIV    = 13020,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [2:0]                    o_dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic [15:0]            r_baud;
    logic [3:0]             r_bit_idx;
    logic                   r_tx;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_tick;
    logic                   w_tx_nxt;
    logic                   w_shift_en;
    logic [DATA_BITS-1:0]   w_head;

    // Handshake: a word transfers on a rising edge where s_valid && s_ready;
    // s_ready depends only on the FIFO level, never on s_valid.
    assign s_ready     = (r_level != LW'(FIFO_DEPTH));
    assign w_push      = s_valid && s_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_tick      = (r_state != S_IDLE) && (r_baud == 16'(CLK_DIV - 1));
    assign tx          = r_tx;
    assign busy        = (r_state != S_IDLE) || (r_level != '0);
    assign fifo_level  = r_level;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = r_tx;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_shift_en  = 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_tx_nxt   = r_shift[0];
                        w_shift_en = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when more words wait.
                if (w_tick && (r_bit_idx == 4'(STOP_BITS - 1))) begin
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            if ((r_state == S_IDLE) || w_tick) r_baud <= '0;
            else                               r_baud <= r_baud + 16'd1;
            if (w_state_nxt != r_state) r_bit_idx <= '0;
            else if (w_tick)            r_bit_idx <= r_bit_idx + 4'd1;
            // Parity is taken from the popped word so later s_data changes cannot affect it.
            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= (^w_head) ^ (PARITY == 1);
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four frame formats, per-cycle tx stream scoreboard.
module tb_uart_tx_cfg;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] sd;
    logic [3:0] vld;
    logic       rdy [4];
    logic       txl [4];
    logic       bsy [4];
    logic [2:0] lvl [4];
    logic [2:0] dbg [4];

    int db_c   [4] = '{8, 8, 8, 5};
    int par_c  [4] = '{2, 1, 0, 0};
    int stop_c [4] = '{1, 1, 1, 2};

    int         sel = 0;
    int         checks = 0;
    int         errors = 0;
    logic [0:0] exp_q [$];
    logic [0:0] mon_b;

    typedef struct {
        int         s;
        logic [8:0] d;
        logic       p;
        int         len;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst_n(rst_n), .s_data(sd[7:0]), .s_valid(vld[0]), .s_ready(rdy[0]),
        .tx(txl[0]), .busy(bsy[0]), .fifo_level(lvl[0]), .o_dbg_state(dbg[0]));
    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .s_data(sd[7:0]), .s_valid(vld[1]), .s_ready(rdy[1]),
        .tx(txl[1]), .busy(bsy[1]), .fifo_level(lvl[1]), .o_dbg_state(dbg[1]));
    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_none (
        .clk(clk), .rst_n(rst_n), .s_data(sd[7:0]), .s_valid(vld[2]), .s_ready(rdy[2]),
        .tx(txl[2]), .busy(bsy[2]), .fifo_level(lvl[2]), .o_dbg_state(dbg[2]));
    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_five (
        .clk(clk), .rst_n(rst_n), .s_data(sd[4:0]), .s_valid(vld[3]), .s_ready(rdy[3]),
        .tx(txl[3]), .busy(bsy[3]), .fifo_level(lvl[3]), .o_dbg_state(dbg[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic par_of(input int s, input logic [8:0] d);
        logic x = 1'b0;
        for (int i = 0; i < db_c[s]; i++) x ^= d[i];
        return (par_c[s] == 1) ? ~x : x;
    endfunction

    task automatic push_bit(input logic b);
        repeat (CLK_DIV) exp_q.push_back(b);
    endtask

    // A word accepted while the line is quiet starts one cycle later.
    task automatic push_frame(input int s, input logic [8:0] d, input logic p);
        if (exp_q.size() == 0) exp_q.push_back(1'b1);
        push_bit(1'b0);
        for (int i = 0; i < db_c[s]; i++) push_bit(d[i]);
        if (par_c[s] != 0) push_bit(p);
        for (int i = 0; i < stop_c[s]; i++) push_bit(1'b1);
    endtask

    task automatic send(input int s, input logic [8:0] d, input logic p, output int waited);
        waited = 0;
        @(negedge clk);
        sd     = d;
        vld[s] = 1'b1;
        while (rdy[s] !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (rdy[s] !== 1'b1) begin
            check("s_ready_wait", 32'(rdy[s]), 32'd1);
            vld[s] = 1'b0;
            return;
        end
        @(posedge clk);
        push_frame(s, d, p);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("busy_after", 32'(bsy[sel]), 32'd0);
        check("level_after", 32'(lvl[sel]), 32'd0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_b = exp_q.pop_front();
            check("tx_bit", 32'(txl[sel]), 32'(mon_b));
        end else begin
            check("tx_idle", 32'(txl[sel]), 32'd1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n;
        logic [8:0] burst [5];

        vecs[0] = '{0, 9'h0A5, 1'b0, 44};
        vecs[1] = '{0, 9'h03C, 1'b0, 44};
        vecs[2] = '{0, 9'h001, 1'b1, 44};
        vecs[3] = '{0, 9'h0FF, 1'b0, 44};
        vecs[4] = '{1, 9'h007, 1'b0, 44};
        vecs[5] = '{1, 9'h003, 1'b1, 44};
        vecs[6] = '{1, 9'h000, 1'b1, 44};
        vecs[7] = '{2, 9'h05A, 1'b0, 40};
        vecs[8] = '{3, 9'h015, 1'b0, 32};
        vecs[9] = '{3, 9'h00A, 1'b0, 32};

        sd  = '0;
        vld = '0;
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 4; s++) begin
            check("rst_tx", 32'(txl[s]), 32'd1);
            check("rst_busy", 32'(bsy[s]), 32'd0);
            check("rst_level", 32'(lvl[s]), 32'd0);
            check("rst_ready", 32'(rdy[s]), 32'd1);
            check("rst_state", 32'(dbg[s]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames: start latency, bit stream and full frame length.
        for (int i = 0; i < 10; i++) begin
            sel = vecs[i].s;
            send(sel, vecs[i].d, vecs[i].p, w);
            @(negedge clk);
            vld[sel] = 1'b0;
            n = 0;
            while (txl[sel] !== 1'b0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("start_latency", 32'(n), 32'd1);
            n = 0;
            while (bsy[sel] === 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("frame_len", 32'(n), 32'(vecs[i].len));
            check("idle_level", 32'(lvl[sel]), 32'd0);
            check("idle_tx", 32'(txl[sel]), 32'd1);
            repeat (3) @(negedge clk);
        end

        // Six cycles of s_valid from idle: five accepted, sixth stalls, nothing lost.
        sel = 0;
        burst = '{9'h011, 9'h022, 9'h0C3, 9'h084, 9'h0F5};
        for (int k = 0; k < 5; k++) begin
            send(0, burst[k], par_of(0, burst[k]), w);
            check("burst_wait", 32'(w), 32'd0);
        end
        @(negedge clk);
        sd     = 9'h0EE;
        vld[0] = 1'b1;
        check("full_ready", 32'(rdy[0]), 32'd0);
        check("full_level", 32'(lvl[0]), 32'd4);
        @(negedge clk);
        check("stall_level", 32'(lvl[0]), 32'd4);
        vld[0] = 1'b0;
        drain(600);

        // Three queued frames with two stop bits, back to back.
        sel = 3;
        send(3, 9'h01F, 1'b0, w);
        send(3, 9'h000, 1'b0, w);
        send(3, 9'h012, 1'b0, w);
        @(negedge clk);
        vld[3] = 1'b0;
        drain(300);

        // Reset during the data bits aborts the frame and empties the FIFO.
        sel = 0;
        send(0, 9'h0A5, par_of(0, 9'h0A5), w);
        send(0, 9'h03C, par_of(0, 9'h03C), w);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_tx", 32'(txl[0]), 32'd1);
        check("abort_level", 32'(lvl[0]), 32'd0);
        check("abort_busy", 32'(bsy[0]), 32'd0);
        check("abort_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_resume", 32'(bsy[0]), 32'd0);
        send(0, 9'h05A, par_of(0, 9'h05A), w);
        @(negedge clk);
        vld[0] = 1'b0;
        drain(200);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 13020, meaning clk cycles per bit; legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 and 2.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of 2, minimum 2.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, meaning reset: asynchronous, active-low.
REQ-008 The block SHALL have port s_data, input, DATA_BITS wide, meaning the word to transmit.
REQ-009 The block SHALL have port s_valid, input, 1 bit, meaning s_data is valid.
REQ-010 The block SHALL have port s_ready, output, 1 bit, meaning the FIFO can accept a word.
REQ-011 The block SHALL have port tx, output, 1 bit, meaning the serial line; it SHALL be registered and idle high.
REQ-012 The block SHALL have port busy, output, 1 bit, meaning a frame is in progress or the FIFO is non-empty.
REQ-013 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, meaning the number of words stored.

Function
REQ-014 A word SHALL be accepted at a rising edge where s_valid and s_ready are both 1.
REQ-015 s_ready SHALL be combinational and equal to (fifo_level != FIFO_DEPTH); a word offered while the FIFO is full SHALL stall, never be dropped.
REQ-016 A push and a pop in the same cycle SHALL leave fifo_level unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-018 IDLE SHALL hold tx=1.
REQ-019 In IDLE, when fifo_level != 0, the FSM SHALL at the next edge pop the head into the shift register, clear the baud counter, set tx=0 and enter START.
REQ-020 The baud counter SHALL count 0..CLK_DIV-1, and every frame bit SHALL last exactly CLK_DIV cycles on tx.
REQ-021 The FSM SHALL advance only on the edge where the counter equals CLK_DIV-1; tx SHALL update on that same edge.
REQ-022 The DATA state SHALL send the data bits LSB first, with a bit index counting 0..DATA_BITS-1.
REQ-023 The PARITY state SHALL be entered only if PARITY != 0.
REQ-024 The parity bit SHALL be the XOR of the data bits when PARITY=2, and its inverse when PARITY=1; it SHALL be computed from the latched word, not from s_data.
REQ-025 The STOP state SHALL drive tx=1 for STOP_BITS*CLK_DIV cycles.
REQ-026 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and go directly to START with no idle cycle between frames.
REQ-027 At the end of STOP, if the FIFO is empty, the FSM SHALL go to IDLE.
REQ-028 The frame length SHALL be exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
REQ-029 With the FIFO empty and the FSM in IDLE, if a word is accepted at edge E, tx SHALL fall at edge E+1.
REQ-030 busy SHALL be (state != IDLE) || (fifo_level != 0).

Reset
REQ-031 When rst_n is asserted, the block SHALL immediately set tx=1, busy=0 and fifo_level=0, clear the FIFO pointers, clear the counters, and set the state to IDLE.
REQ-032 s_ready SHALL be 1 during reset.
REQ-033 An assertion of rst_n mid-frame SHALL abort the frame, with tx returning high asynchronously; transmission SHALL resume only on new input.

Verification
REQ-034 With CLK_DIV=4, DATA_BITS=8 and PARITY=2, pushing 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each level held 4 cycles, 44 cycles total, after which busy=0.
REQ-035 With PARITY=1 and 0x07 -> parity bit 0; with PARITY=1 and 0x03 -> parity bit 1; with PARITY=0 -> no parity slot and a 40-cycle frame.
REQ-036 With FIFO_DEPTH=4 and s_valid held for 6 consecutive cycles from idle -> 5 words accepted (the first is popped immediately), s_ready low on the 6th, fifo_level=4, no word lost.
REQ-037 Three words queued -> frames back-to-back with the next start bit immediately after the last stop cycle and no extra high cycle; bytes are transmitted in order.
REQ-038 With STOP_BITS=2 and DATA_BITS=5 -> the stop high lasts 2*CLK_DIV cycles, and the frame is 8*CLK_DIV cycles with parity off.
REQ-039 rst_n pulsed low during the data bits -> tx=1 within the same cycle and fifo_level=0; a new word afterwards transmits correctly.
